// File: rtl/vector_checker_pkg.sv
// rtl/vector_checker_pkg.sv - shared types, constants and LFSR step for the vector checker
package vector_checker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST_HOLD,
    REL,
    DRIVE,
    WAIT,
    DONE
  } state_t;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [15:0] SATURATE  = 16'hFFFF;

  // Galois step: shift right, fold the mask back in when a one falls out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

endpackage

// File: rtl/vc_lfsr.sv
// rtl/vc_lfsr.sv - 32-bit Galois LFSR with seed load and step enable
module vc_lfsr
  import vector_checker_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  logic [31:0] value_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= seed;
    end else if (load) begin
      value_q <= seed;
    end else if (step) begin
      value_q <= lfsr_next(value_q);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/vector_checker.sv
// rtl/vector_checker.sv - drives random vectors into two DUT copies and counts response mismatches
module vector_checker
  import vector_checker_pkg::*;
#(
  parameter int          IN_W    = 8,
  parameter int          OUT_W   = 32,
  parameter int          NUM_VEC = 1000,
  parameter int          SETTLE  = 2,
  parameter logic [31:0] SEED    = 32'h1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OUT_W-1:0] golden_out,
  input  logic [OUT_W-1:0] netlist_out,
  output logic             dut_rst,
  output logic [IN_W-1:0]  stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             rst_fail,
  output logic [15:0]      mismatch_cnt,
  output logic [15:0]      vec_cnt,
  output logic [15:0]      first_fail_idx
);

  localparam logic [31:0] SEED_EFF    = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [15:0] NUM_VEC_W   = 16'(NUM_VEC);
  localparam logic [15:0] LAST_SETTLE = 16'(SETTLE - 1);

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [IN_W-1:0]   stim_q, stim_d;
  logic              rst_fail_q, rst_fail_d;
  logic [15:0]       mism_q, mism_d;
  logic [15:0]       vec_q, vec_d;
  logic [15:0]       ffi_q, ffi_d;
  logic              lfsr_load, lfsr_step;
  logic [31:0]       lfsr_val;
  logic              equal;

  vc_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (SEED_EFF),
    .value (lfsr_val)
  );

  assign equal = (golden_out == netlist_out);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stim_d     = stim_q;
    rst_fail_d = rst_fail_q;
    mism_d     = mism_q;
    vec_d      = vec_q;
    ffi_d      = ffi_q;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RST_HOLD;
          cnt_d      = '0;
          stim_d     = '0;
          rst_fail_d = 1'b0;
          mism_d     = '0;
          vec_d      = '0;
          ffi_d      = SATURATE;
          lfsr_load  = 1'b1;
        end
      end
      RST_HOLD: begin
        if (cnt_q == 16'd1) begin
          cnt_d   = '0;
          state_d = REL;
          if (!equal) begin
            rst_fail_d = 1'b1;
            mism_d     = (mism_q == SATURATE) ? mism_q : mism_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      REL: begin
        // Stim changes on the edge entering DRIVE, so DRIVE is settle cycle one.
        state_d   = DRIVE;
        cnt_d     = '0;
        lfsr_step = 1'b1;
        stim_d    = IN_W'(lfsr_next(lfsr_val));
      end
      DRIVE, WAIT: begin
        if (cnt_q == LAST_SETTLE) begin
          cnt_d = '0;
          if (!equal) begin
            mism_d = (mism_q == SATURATE) ? mism_q : mism_q + 16'd1;
            if (ffi_q == SATURATE) ffi_d = vec_q;
          end
          vec_d = vec_q + 16'd1;
          if (vec_q + 16'd1 == NUM_VEC_W) begin
            state_d = DONE;
            stim_d  = '0;
          end else begin
            state_d   = DRIVE;
            lfsr_step = 1'b1;
            stim_d    = IN_W'(lfsr_next(lfsr_val));
          end
        end else begin
          cnt_d   = cnt_q + 16'd1;
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      stim_q     <= '0;
      rst_fail_q <= 1'b0;
      mism_q     <= '0;
      vec_q      <= '0;
      ffi_q      <= SATURATE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stim_q     <= stim_d;
      rst_fail_q <= rst_fail_d;
      mism_q     <= mism_d;
      vec_q      <= vec_d;
      ffi_q      <= ffi_d;
    end
  end

  assign dut_rst        = (state_q == IDLE) || (state_q == RST_HOLD) || (state_q == DONE);
  assign busy           = (state_q == RST_HOLD) || (state_q == REL) ||
                          (state_q == DRIVE) || (state_q == WAIT);
  assign done           = (state_q == DONE);
  assign pass           = done && (mism_q == 16'd0);
  assign stim           = stim_q;
  assign rst_fail       = rst_fail_q;
  assign mismatch_cnt   = mism_q;
  assign vec_cnt        = vec_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: doc/vector_checker.md
VECTOR_CHECKER -- requirements
Module: vector_checker

Interface
REQ-001 SHALL have parameter IN_W, default 8: DUT stimulus width.
REQ-002 SHALL have parameter OUT_W, default 32: DUT response width.
REQ-003 SHALL have parameter NUM_VEC, default 1000: number of random vectors per run (1..65535).
REQ-004 SHALL have parameter SETTLE, default 2: cycles from stimulus update to compare (>=1).
REQ-005 SHALL have parameter SEED, default 32'h1: LFSR seed; a SEED of 0 SHALL be replaced by 1.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1 bit: run request, sampled high in IDLE or DONE.
REQ-009 SHALL have port golden_out, input, OUT_W bits: reference model response.
REQ-010 SHALL have port netlist_out, input, OUT_W bits: implementation-under-test response.
REQ-011 SHALL have port dut_rst, output, 1 bit: active-high reset driven to both DUT copies.
REQ-012 SHALL have port stim, output, IN_W bits: registered stimulus to both DUT copies.
REQ-013 SHALL have ports busy and done, outputs, 1 bit each: run in progress / run complete (level).
REQ-014 SHALL have port pass, output, 1 bit: valid when done; 1 when no mismatch occurred.
REQ-015 SHALL have port rst_fail, output, 1 bit: the reset-phase compare mismatched.
REQ-016 SHALL have ports mismatch_cnt, vec_cnt and first_fail_idx, outputs, 16 bits each.

Function
REQ-017 SHALL implement FSM states IDLE, RST_HOLD, REL, DRIVE, WAIT, DONE.
REQ-018 IDLE/DONE: dut_rst=1, stim=0; start=1 SHALL clear all counters and flags, reseed LFSR, and enter RST_HOLD.
REQ-019 RST_HOLD SHALL last 2 cycles with dut_rst=1; on its last cycle it SHALL compare golden_out to netlist_out, setting rst_fail and incrementing mismatch_cnt on inequality.
REQ-020 REL SHALL last 1 cycle with dut_rst=0, stim=0, and no compare.
REQ-021 DRIVE SHALL step the LFSR, load stim with LFSR[IN_W-1:0] (post-step value), and enter WAIT.
REQ-022 The bench SHALL compare in the SETTLE-th cycle after stim updates; on mismatch it SHALL increment mismatch_cnt and, if this is the first vector-phase failure, capture vec_cnt into first_fail_idx; vec_cnt SHALL then increment.
REQ-023 After the compare, the FSM SHALL go to DONE if vec_cnt reaches NUM_VEC, else to DRIVE; the DRIVE cycle SHALL count as the first settle cycle.
REQ-024 done SHALL assert exactly 3 + NUM_VEC*SETTLE cycles after the edge that samples start.
REQ-025 pass SHALL be (mismatch_cnt==0) and SHALL hold with done until the next start.
REQ-026 Equality SHALL be full OUT_W bitwise; mismatch_cnt SHALL saturate at 16'hFFFF; first_fail_idx SHALL read 16'hFFFF when no vector failed.
REQ-027 The LFSR SHALL be a 32-bit Galois LFSR, mask 32'h80200003, shifting right and XORing the mask when the shifted-out bit is 1.
REQ-028 busy SHALL be 1 in RST_HOLD, REL, DRIVE and WAIT; start while busy SHALL be ignored.

Reset
REQ-029 On rst low, the block SHALL immediately enter IDLE with dut_rst=1, stim=0, busy=0, done=0, pass=0, rst_fail=0, mismatch_cnt=0, vec_cnt=0, first_fail_idx=16'hFFFF, and LFSR=SEED; this SHALL apply mid-run too.

Structure
REQ-030 Package vector_checker_pkg SHALL hold the state enum, the LFSR mask constant, and the SATURATE value 16'hFFFF.
REQ-031 The LFSR SHALL be sub-module vc_lfsr (ports clk, rst, load, step, seed, value).

Verification
REQ-032 netlist_out tied to golden_out, NUM_VEC=16, SETTLE=2 -> done at start+35, pass=1, mismatch_cnt=0, vec_cnt=16, first_fail_idx=FFFF.
REQ-033 netlist_out = golden_out^1 always, NUM_VEC=16 -> rst_fail=1, mismatch_cnt=17, first_fail_idx=0, pass=0.
REQ-034 Single bit-31 flip on the vector-5 compare only -> mismatch_cnt=1, first_fail_idx=5, rst_fail=0, pass=0.
REQ-035 SEED=1: first stim = 8'h03, then the LFSR-model sequence; a second start from DONE -> identical sequence.
REQ-036 rst low during WAIT of vector 7 -> all outputs take reset values in the same cycle; start pulse while busy -> no restart, done timing unchanged.
